// File: rtl/accuracy_monitor.sv
// Classification scoreboard: saturating sample/correct counters plus a restoring
// divider that reports floor(100*correct/total). Optional macro: PER_CLASS_EN.
module accuracy_monitor #(
  parameter int CLASS_W     = 8,
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               sample_valid,
  input  logic [CLASS_W-1:0] predicted,
  input  logic [CLASS_W-1:0] label,
  input  logic               report_req,
  input  logic [CLASS_W-1:0] class_sel,
  output logic [CNT_W-1:0]   total_count,
  output logic [CNT_W-1:0]   correct_count,
  output logic [CNT_W-1:0]   class_hits,
  output logic [6:0]         accuracy,
  output logic               acc_valid,
  output logic               busy,
  output logic               div_by_zero,
  output logic               saturated,
  output logic               bad_label
);

  localparam int NUM_W = CNT_W + 7;
  localparam int CW    = $clog2(NUM_W);
  localparam logic [CNT_W-1:0]   CNT_MAX       = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE       = CNT_W'(1'b1);
  localparam logic [CLASS_W-1:0] NUM_CLASSES_C = CLASS_W'(NUM_CLASSES);
  localparam logic [NUM_W-1:0]   HUNDRED       = NUM_W'(7'd100);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  logic [CNT_W-1:0] total_q, correct_q;
  logic             sat_q, bad_q;
  logic             valid_label_s, accept_s, hit_s;

  state_e           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [CNT_W:0]   rem_shift_s;
  logic [CNT_W-1:0] rem_sub_s;
  logic             rem_ge_s;

  logic [6:0]       accuracy_q;
  logic             acc_valid_q, busy_q, dz_q;

  assign valid_label_s = (label < NUM_CLASSES_C);
  // Once total is at max the whole sample is dropped so the ratio stays consistent.
  assign accept_s      = sample_valid && (total_q != CNT_MAX);
  assign hit_s         = accept_s && valid_label_s && (predicted == label);

  // Sample counters and sticky status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_q   <= {CNT_W{1'b0}};
      correct_q <= {CNT_W{1'b0}};
      sat_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else if (clear) begin
      total_q   <= {CNT_W{1'b0}};
      correct_q <= {CNT_W{1'b0}};
      sat_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      if (accept_s) total_q <= total_q + CNT_ONE;
      if (hit_s) correct_q <= correct_q + CNT_ONE;
      if (sample_valid && !accept_s) sat_q <= 1'b1;
      if (sample_valid && !valid_label_s) bad_q <= 1'b1;
    end
  end

  // Remainder never exceeds den-1, so the low CNT_W bits of the difference are exact.
  assign rem_shift_s = {rem_q, num_q[NUM_W-1]};
  assign rem_ge_s    = (rem_shift_s >= {1'b0, den_q});
  assign rem_sub_s   = rem_shift_s[CNT_W-1:0] - den_q;

  // Report FSM next-state and divider datapath.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (report_req) begin
          zero_d  = (total_q == {CNT_W{1'b0}});
          num_d   = NUM_W'(correct_q) * HUNDRED;
          den_d   = total_q;
          rem_d   = {CNT_W{1'b0}};
          cnt_d   = CW'(NUM_W - 1);
          state_d = (total_q == {CNT_W{1'b0}}) ? S_DONE : S_DIV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        if (rem_ge_s) begin
          rem_d = rem_sub_s;
          num_d = {num_q[NUM_W-2:0], 1'b1};
        end else begin
          rem_d = rem_shift_s[CNT_W-1:0];
          num_d = {num_q[NUM_W-2:0], 1'b0};
        end
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1'b1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // FSM and divider registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      num_q   <= {NUM_W{1'b0}};
      den_q   <= {CNT_W{1'b0}};
      rem_q   <= {CNT_W{1'b0}};
      cnt_q   <= {CW{1'b0}};
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  // Registered report outputs; clear suppresses a pending pulse but keeps accuracy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accuracy_q  <= 7'd0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else if (clear) begin
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      busy_q <= (state_d == S_DIV);
      if (state_q == S_DONE) begin
        acc_valid_q <= 1'b1;
        accuracy_q  <= zero_q ? 7'd0 : num_q[6:0];
        dz_q        <= zero_q;
      end else begin
        acc_valid_q <= 1'b0;
      end
    end
  end

`ifdef PER_CLASS_EN
  logic [CNT_W-1:0] class_cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] class_hits_s;

  // Per-class hit counters, bumped only by accepted correct samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) class_cnt_q[i] <= {CNT_W{1'b0}};
    end else if (clear) begin
      for (int i = 0; i < NUM_CLASSES; i++) class_cnt_q[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (hit_s && (label == CLASS_W'(i)) && (class_cnt_q[i] != CNT_MAX))
          class_cnt_q[i] <= class_cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Combinational per-class readback; out-of-range selects read as zero.
  always_comb begin
    class_hits_s = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_CLASSES; i++)
      class_hits_s = (class_sel == CLASS_W'(i)) ? class_cnt_q[i] : class_hits_s;
  end

  assign class_hits = class_hits_s;
`else
  logic unused_class_sel_s;
  assign unused_class_sel_s = ^class_sel;
  assign class_hits         = {CNT_W{1'b0}};
`endif

  assign total_count   = total_q;
  assign correct_count = correct_q;
  assign saturated     = sat_q;
  assign bad_label     = bad_q;
  assign accuracy      = accuracy_q;
  assign acc_valid     = acc_valid_q;
  assign busy          = busy_q;
  assign div_by_zero   = dz_q;

endmodule

// File: tb/tb_accuracy_monitor.sv
// Self-checking bench for accuracy_monitor: default instance plus a CNT_W=4
// instance sharing stimulus; report results go through a scoreboard queue.
module tb_accuracy_monitor;

  logic       clk = 1'b0;
  logic       rst, clear, sample_valid, report_req;
  logic [7:0] predicted, label, class_sel;

  logic [15:0] total_count, correct_count, class_hits;
  logic [6:0]  accuracy;
  logic        acc_valid, busy, div_by_zero, saturated, bad_label;

  logic [3:0]  total_count4, correct_count4, class_hits4;
  logic [6:0]  accuracy4;
  logic        acc_valid4, busy4, div_by_zero4, saturated4, bad_label4;

  always #5 clk = ~clk;

  accuracy_monitor dut (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .predicted(predicted), .label(label), .report_req(report_req), .class_sel(class_sel),
    .total_count(total_count), .correct_count(correct_count), .class_hits(class_hits),
    .accuracy(accuracy), .acc_valid(acc_valid), .busy(busy), .div_by_zero(div_by_zero),
    .saturated(saturated), .bad_label(bad_label)
  );

  accuracy_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .predicted(predicted), .label(label), .report_req(report_req), .class_sel(class_sel),
    .total_count(total_count4), .correct_count(correct_count4), .class_hits(class_hits4),
    .accuracy(accuracy4), .acc_valid(acc_valid4), .busy(busy4), .div_by_zero(div_by_zero4),
    .saturated(saturated4), .bad_label(bad_label4)
  );

  typedef struct {
    logic [7:0] p;
    logic [7:0] l;
    int         tot;
    int         cor;
  } vec_t;

  typedef struct {
    int acc;
    int dz;
    int cyc;
  } exp_t;

  vec_t vecs[7];
  exp_t q[$];
  exp_t q4[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   pulses = 0;
  int   pushes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any acc_valid pulse seen there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (acc_valid) begin
      pulses++;
      check("acc_valid_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("accuracy", int'(accuracy), e.acc);
        check("div_by_zero", int'(div_by_zero), e.dz);
        check("acc_latency", cyc, e.cyc);
      end
    end
    if (acc_valid4) begin
      pulses++;
      check("acc_valid_expected_w4", int'(q4.size() > 0), 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check("accuracy_w4", int'(accuracy4), e.acc);
        check("div_by_zero_w4", int'(div_by_zero4), e.dz);
        check("acc_latency_w4", cyc, e.cyc);
      end
    end
  endtask

  task automatic sample(input logic [7:0] p, input logic [7:0] l);
    sample_valid = 1'b1;
    predicted    = p;
    label        = l;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic report(input int a, input int dz, input int lat,
                        input int a4, input int dz4, input int lat4);
    exp_t e;
    report_req = 1'b1;
    e.acc = a;  e.dz = dz;  e.cyc = cyc + 1 + lat;  q.push_back(e);
    e.acc = a4; e.dz = dz4; e.cyc = cyc + 1 + lat4; q4.push_back(e);
    pushes += 2;
    tick();
    report_req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && (q.size() > 0 || q4.size() > 0); i++) tick();
    check("scoreboard_drained", int'(q.size() + q4.size()), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int seen;
    vecs[0] = '{8'd3, 8'd3, 1, 1};
    vecs[1] = '{8'd5, 8'd5, 2, 2};
    vecs[2] = '{8'd1, 8'd2, 3, 2};
    vecs[3] = '{8'd7, 8'd7, 4, 3};
    vecs[4] = '{8'd2, 8'd2, 1, 1};
    vecs[5] = '{8'd2, 8'd2, 2, 2};
    vecs[6] = '{8'd4, 8'd1, 3, 2};

    rst = 1'b0; clear = 1'b0; sample_valid = 1'b0; report_req = 1'b0;
    predicted = 8'd0; label = 8'd0; class_sel = 8'd2;
    tick(); tick();
    check("rst_total", int'(total_count), 0);
    check("rst_correct", int'(correct_count), 0);
    check("rst_accuracy", int'(accuracy), 0);
    check("rst_flags", int'({acc_valid, busy, div_by_zero, saturated, bad_label}), 0);
    check("rst_class_hits", int'(class_hits), 0);
    rst = 1'b1;
    tick();

    // Report with nothing counted: one-cycle answer flagged as divide-by-zero.
    report(0, 1, 1, 0, 1, 1);
    wait_done();

    for (int i = 0; i < 4; i++) begin
      sample(vecs[i].p, vecs[i].l);
      check("tbl_total", int'(total_count), vecs[i].tot);
      check("tbl_correct", int'(correct_count), vecs[i].cor);
      check("tbl_bad_label", int'(bad_label), 0);
    end
    report(75, 0, 24, 75, 0, 12);
    check("busy_in_div", int'(busy), 1);
    wait_done();
    check("busy_after_done", int'(busy), 0);

    // Clear five cycles into the division aborts it silently.
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("busy_before_clear", int'(busy), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("busy_after_clear", int'(busy), 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen = seen | int'(acc_valid) | int'(acc_valid4);
    end
    check("no_acc_after_clear", seen, 0);
    check("clear_total", int'(total_count), 0);
    check("clear_correct", int'(correct_count), 0);
    check("clear_keeps_accuracy", int'(accuracy), 75);
    check("clear_keeps_accuracy_w4", int'(accuracy4), 75);

    // Reset in the middle of a division.
    sample(8'd1, 8'd1);
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("midrst_counts", int'({total_count, correct_count}), 0);
    check("midrst_accuracy", int'(accuracy), 0);
    check("midrst_accuracy_w4", int'(accuracy4), 0);
    check("midrst_flags", int'({acc_valid, busy, div_by_zero, saturated, bad_label}), 0);
    rst = 1'b1;
    tick();
    for (int i = 4; i < 7; i++) begin
      sample(vecs[i].p, vecs[i].l);
      check("tbl2_total", int'(total_count), vecs[i].tot);
      check("tbl2_correct", int'(correct_count), vecs[i].cor);
    end
`ifdef PER_CLASS_EN
    check("class_hits_sel2", int'(class_hits), 2);
`else
    check("class_hits_tied", int'(class_hits), 0);
`endif
    report(66, 0, 24, 66, 0, 12);
    wait_done();

    // Sample and report in the same cycle: snapshot excludes the new sample.
    do_clear();
    sample(8'd4, 8'd4);
    check("same_pre_total", int'(total_count), 1);
    sample_valid = 1'b1;
    predicted    = 8'd6;
    label        = 8'd6;
    report(100, 0, 24, 100, 0, 12);
    sample_valid = 1'b0;
    check("same_total", int'(total_count), 2);
    check("same_correct", int'(correct_count), 2);
    wait_done();
    check("same_total_after", int'(total_count), 2);

    sample(8'd12, 8'd12);
    check("bad_label_set", int'(bad_label), 1);
    check("bad_label_total", int'(total_count), 3);
    check("bad_label_correct", int'(correct_count), 2);

    // Saturation on the narrow instance; an extra report while busy is ignored.
    do_clear();
    check("clear_bad_label", int'(bad_label), 0);
    for (int k = 0; k < 20; k++) sample(8'(k % 10), 8'(k % 10));
    check("sat_total_w4", int'(total_count4), 15);
    check("sat_correct_w4", int'(correct_count4), 15);
    check("sat_flag_w4", int'(saturated4), 1);
    check("sat_total", int'(total_count), 20);
    check("sat_flag", int'(saturated), 0);
    report(100, 0, 24, 100, 0, 12);
    tick(); tick();
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    wait_done();
    for (int i = 0; i < 30; i++) tick();
    check("pulse_count", pulses, pushes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accuracy_monitor.md
Name: accuracy_monitor

Overview:
- Synthesizable classification scoreboard that replaces bench-side accuracy counting.
- Sits beside NeuralNetwork. Each sample_valid pulse (tied to batch_done) compares the predicted class against the reference label.
- Keeps saturating total and correct counters.
- On request, computes integer accuracy percent, floor(100*correct/total), with a multi-cycle restoring divider.

Parameters:
- CLASS_W, 8, width of predicted and label.
- NUM_CLASSES, 10, number of valid class codes (0..NUM_CLASSES-1).
- CNT_W, 16, width of the sample counters.
- Derived, not overridable: NUM_W = CNT_W+7, the numerator width for correct*100.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of counters and flags; aborts any division.
- sample_valid  in  1  one-cycle strobe: predicted and label are valid.
- predicted  in  CLASS_W  network result.
- label  in  CLASS_W  reference class.
- report_req  in  1  one-cycle strobe: start accuracy computation.
- class_sel  in  CLASS_W  per-class counter select (PER_CLASS_EN).
- total_count  out  CNT_W  samples counted.
- correct_count  out  CNT_W  samples with predicted==label.
- class_hits  out  CNT_W  correct count for class_sel.
- accuracy  out  7  percent, 0..100.
- acc_valid  out  1  one-cycle pulse, accuracy updated.
- busy  out  1  division in progress.
- div_by_zero  out  1  last report had total=0.
- saturated  out  1  sticky, counters hit max.
- bad_label  out  1  sticky, a label >= NUM_CLASSES was seen.

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; all counters 0.
- Counting (independent of FSM, runs while busy):
  - On sample_valid, if total_count != 2^CNT_W-1: total+1; correct+1 if predicted==label and label<NUM_CLASSES.
  - If total_count == max: sample dropped, saturated set. Both counters freeze together, so the ratio stays consistent.
  - label>=NUM_CLASSES: counted in total, never correct, bad_label set.
- clear (sync):
  - Zeroes counters, saturated, bad_label and div_by_zero; accuracy holds.
  - FSM goes to IDLE and no acc_valid pulse occurs.
  - clear beats a simultaneous sample_valid or report_req.
- FSM IDLE, report_req=1:
  - Snapshot total/correct values from before any same-cycle sample update.
  - If snapshot total=0: go to DONE.
  - Else: load numerator=correct*100 (NUM_W bits), denominator=total; go to DIV.
- FSM DIV:
  - busy=1. Restoring division, one quotient bit per cycle, MSB first, exactly NUM_W cycles, then DONE.
  - report_req while busy: ignored.
- FSM DONE (1 cycle):
  - accuracy <= quotient[6:0]; quotient is ≤100 because correct≤total.
  - div_by_zero <= (snapshot total==0); for total=0, accuracy <= 0.
  - acc_valid=1 this cycle; busy=0; return to IDLE.
- Latency: acc_valid high NUM_W+1 cycles after the report_req sampling edge (24 for CNT_W=16), or 1 cycle when total=0. report_req is accepted again in the cycle after DONE.
- Reset asserted mid-division: immediate IDLE, everything 0, no pulse.

Optional Feature:
- PER_CLASS_EN defined:
  - NUM_CLASSES saturating CNT_W counters, one per class.
  - The selected label's counter increments on each accepted correct sample.
  - Counters are cleared by rst and clear.
  - class_hits = counter[class_sel] combinationally; 0 if class_sel>=NUM_CLASSES.
- Undefined: no per-class storage; class_hits tied to 0; class_sel ignored.

Test Plan:
- Reset, then 4 samples (3,3),(5,5),(1,2),(7,7), then report_req -> total=4, correct=3; acc_valid after 24 cycles; accuracy=75; div_by_zero=0.
- report_req straight after reset -> acc_valid 1 cycle later; accuracy=0; div_by_zero=1.
- CNT_W=4, 20 all-correct samples -> total=15, correct=15, saturated=1; report gives accuracy=100.
- clear asserted 5 cycles into DIV -> busy drops next cycle; no acc_valid; counters 0; accuracy retains previous 75.
- rst low mid-DIV, then 3 samples (2,2),(2,2),(4,1) -> all outputs 0 during reset; after it, report yields accuracy=66. With PER_CLASS_EN, class_sel=2 shows class_hits=2.
- sample_valid and report_req in same cycle after 1 correct sample, second sample correct -> accuracy=100 (snapshot total=1); total_count=2 afterwards. Label 12 with NUM_CLASSES=10 -> bad_label=1.
